check_node_min_sum_serial: RTL and testbench

- Serial min-sum check-node accumulator for the LDPC belief-propagation decoder.
- Consumes one IEEE-754 single-precision variable-to-check LLR per accepted beat over DEGREE beats.
- Produces the smallest magnitude (min1), the second-smallest magnitude (min2), the edge index of min1, and the XOR of all sign bits.
- Sits directly downstream of the floating-point less-than comparator, which it instantiates to rank magnitudes. Feeds the check-to-variable message write-back stage.

---
 rtl/check_node_min_sum_serial_pkg.sv | 12 +
 rtl/check_node_min_sum_serial_comparator.sv | 32 +++
 rtl/check_node_min_sum_serial.sv | 105 ++++++++++
 tb/tb_check_node_min_sum_serial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/check_node_min_sum_serial_pkg.sv
// Shared constants for the serial min-sum check-node: FSM encoding and
// IEEE-754 single-precision field positions.
package check_node_min_sum_serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam int          SIGN_BIT   = 31;

endpackage

// File: rtl/check_node_min_sum_serial_comparator.sv
// Combinational IEEE-754 single-precision less-than (a < b); NaN handling
// is outside its contract, and +0 / -0 compare equal.
module comparator_floating_point
    import check_node_min_sum_serial_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    logic a_neg;
    logic b_neg;
    logic both_zero;

    assign a_neg     = a[SIGN_BIT];
    assign b_neg     = b[SIGN_BIT];
    assign both_zero = (a[SIGN_BIT-1:0] == '0) && (b[SIGN_BIT-1:0] == '0);

    always_comb begin
        lt = 1'b0;
        if (both_zero)
            lt = 1'b0;
        else if (a_neg != b_neg)
            lt = a_neg;
        else if (!a_neg)
            lt = (a[SIGN_BIT-1:0] < b[SIGN_BIT-1:0]);
        else
            // both negative: larger magnitude is the smaller value
            lt = (a[SIGN_BIT-1:0] > b[SIGN_BIT-1:0]);
    end

endmodule

// File: rtl/check_node_min_sum_serial.sv
// Serial min-sum check-node: tracks min1, min2, index of min1 and the sign
// parity over DEGREE accepted LLR beats, then holds the result until taken.
module check_node_min_sum_serial
    import check_node_min_sum_serial_pkg::*;
#(
    parameter int DEGREE = 6,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min1,
    output logic [31:0]      out_min2,
    output logic [IDX_W-1:0] out_min1_idx,
    output logic             out_sign
);

    logic [1:0]       state;
    // one extra bit so the count can represent DEGREE == 2^IDX_W
    logic [IDX_W:0]   count;
    logic [31:0]      min1;
    logic [31:0]      min2;
    logic [IDX_W-1:0] idx;
    logic             sign;

    logic [31:0] mag;
    logic        lt_min1;
    logic        lt_min2;
    logic        accept;
    logic        last_beat;

    assign mag       = {1'b0, in_data[SIGN_BIT-1:0]};
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (count == (IDX_W+1)'(DEGREE - 1));

    comparator_floating_point u_cmp_min1 (
        .a  (mag),
        .b  (min1),
        .lt (lt_min1)
    );

    comparator_floating_point u_cmp_min2 (
        .a  (mag),
        .b  (min2),
        .lt (lt_min2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            min1  <= FP_POS_INF;
            min2  <= FP_POS_INF;
            idx   <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        min1  <= FP_POS_INF;
                        min2  <= FP_POS_INF;
                        idx   <= '0;
                        sign  <= 1'b0;
                        count <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        sign  <= sign ^ in_data[SIGN_BIT];
                        count <= count + 1'b1;
                        // strict compares: a tie with min1 keeps the first index
                        if (lt_min1) begin
                            min2 <= min1;
                            min1 <= mag;
                            idx  <= count[IDX_W-1:0];
                        end else if (lt_min2) begin
                            min2 <= mag;
                        end
                        if (last_beat)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_min1     = min1;
    assign out_min2     = min2;
    assign out_min1_idx = idx;
    assign out_sign     = sign;

endmodule

// File: tb/tb_check_node_min_sum_serial.sv
// Directed-vector bench for check_node_min_sum_serial with hand-computed
// expected results; inputs driven and outputs sampled on the falling edge.
module tb_check_node_min_sum_serial;
    localparam int DEGREE = 6;
    localparam int IDX_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_min1;
    logic [31:0]      out_min2;
    logic [IDX_W-1:0] out_min1_idx;
    logic             out_sign;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] vec [DEGREE];

    check_node_min_sum_serial #(.DEGREE(DEGREE), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_min1     (out_min1),
        .out_min2     (out_min2),
        .out_min1_idx (out_min1_idx),
        .out_sign     (out_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_node(input bit gaps);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DEGREE; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
            if (i == DEGREE - 1)
                chk("out_valid_early", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            if (gaps && i != DEGREE - 1) begin
                in_valid = 1'b0;
                in_data  = 32'h00000000;
                chk("bubble_no_done", {31'd0, out_valid}, 32'd0);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] m1, input logic [31:0] m2,
                                input logic [31:0] ix, input logic [31:0] sg);
        chk({tag, "_min1"}, out_min1, m1);
        chk({tag, "_min2"}, out_min2, m2);
        chk({tag, "_idx"}, {29'd0, out_min1_idx}, ix);
        chk({tag, "_sign"}, {31'd0, out_sign}, sg);
    endtask

    task automatic finish_node(input int hold);
        logic [31:0] m1, m2;
        m1 = out_min1;
        m2 = out_min2;
        for (int i = 0; i < hold; i++) begin
            start     = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_min1", out_min1, m1);
            chk("hold_min2", out_min2, m2);
        end
        // start coincides with the handshake and must be ignored
        start     = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("idle_stays", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 32'h7F800000, 32'h7F800000, 32'd0, 32'd0);

        vec = '{32'h3F99999A, 32'hBF000000, 32'h42C80000, 32'h3E99999A, 32'h40000000, 32'hC0400000};
        run_node(1'b0);
        check_result("basic", 32'h3E99999A, 32'h3F000000, 32'd3, 32'd0);
        finish_node(0);

        vec = '{32'h42C80000, 32'h40400000, 32'h40000000, 32'h3F99999A, 32'h3F000000, 32'h3E99999A};
        run_node(1'b0);
        check_result("desc", 32'h3E99999A, 32'h3F000000, 32'd5, 32'd0);
        finish_node(0);

        vec = '{32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h80000000, 32'h00000000};
        run_node(1'b0);
        check_result("zeros", 32'h00000000, 32'h00000000, 32'd4, 32'd1);
        finish_node(0);

        vec = '{32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000};
        run_node(1'b0);
        check_result("ties", 32'h42C80000, 32'h42C80000, 32'd0, 32'd0);
        finish_node(0);

        vec = '{32'h3F99999A, 32'hBF000000, 32'h42C80000, 32'h3E99999A, 32'h40000000, 32'hC0400000};
        run_node(1'b1);
        check_result("bubbles", 32'h3E99999A, 32'h3F000000, 32'd3, 32'd0);
        finish_node(3);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("midrst", 32'h7F800000, 32'h7F800000, 32'd0, 32'd0);
        @(negedge clk);
        chk("midrst_idle", {31'd0, in_ready}, 32'd0);
        run_node(1'b0);
        check_result("after_rst", 32'h3E99999A, 32'h3F000000, 32'd3, 32'd0);
        finish_node(0);

        vec = '{32'hBF99999A, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        run_node(1'b0);
        check_result("oddsign", 32'h3F99999A, 32'h40000000, 32'd0, 32'd1);
        finish_node(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
